// File: rtl/tawas_axi_load.sv
// tawas_axi_load: per-slice AXI load-return engine feeding the register-file write port.
// Define TAWAS_AXI_LOAD_ERR_EN to add the sticky per-slice LD_ERR flag driven by RRESP.

module tawas_axi_load_slice (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       set,
    input  logic       clr,
    input  logic [2:0] set_sel,
    input  logic [1:0] set_size,
    input  logic       set_signed,
    input  logic [1:0] set_lane,
    output logic       busy,
    output logic [2:0] ctx_sel,
    output logic [1:0] ctx_size,
    output logic       ctx_signed,
    output logic [1:0] ctx_lane
);
    // set and clr never coincide: accept needs ~busy, a matched return needs busy
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy       <= 1'b0;
            ctx_sel    <= '0;
            ctx_size   <= '0;
            ctx_signed <= 1'b0;
            ctx_lane   <= '0;
        end else if (set) begin
            busy       <= 1'b1;
            ctx_sel    <= set_sel;
            ctx_size   <= set_size;
            ctx_signed <= set_signed;
            ctx_lane   <= set_lane;
        end else if (clr) begin
            busy       <= 1'b0;
        end
    end
endmodule

module tawas_axi_load #(
    parameter int AR_FIFO_DEPTH = 4,  // >= 4 so every slice's request always fits
    parameter int WB_REG        = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LD_REQ,
    input  logic [1:0]  LD_SLICE,
    input  logic [2:0]  LD_SEL,
    input  logic [31:0] LD_ADDR,
    input  logic [1:0]  LD_SIZE,
    input  logic        LD_SIGNED,
    output logic        LD_RDY,
    output logic [3:0]  LD_BUSY,
`ifdef TAWAS_AXI_LOAD_ERR_EN
    output logic [3:0]  LD_ERR,
`endif
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    output logic [1:0]  ARID,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [1:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    output logic        AXI_LOAD_VLD,
    output logic [1:0]  AXI_LOAD_SLICE,
    output logic [2:0]  AXI_LOAD_SEL,
    output logic [31:0] AXI_LOAD
);
    localparam int PW = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(AR_FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(AR_FIFO_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [31:0] ld_extract(input logic [31:0] d, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lane, 3'b000} +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    return {{24{sgn & b[7]}}, b};
            2'd1:    return {{16{sgn & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    // ---------------- request accept / AR issue queue ----------------
    logic [AR_FIFO_DEPTH-1:0][31:0] ar_mem;  // {slice, addr[31:2]}
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ar_cnt;
    logic          ar_push, ar_pop;

    assign LD_RDY  = LD_REQ & ~LD_BUSY[LD_SLICE];
    assign ar_push = LD_RDY;
    assign ARVALID = (ar_cnt != '0);
    assign ar_pop  = ARVALID & ARREADY;
    assign ARID    = ar_mem[rd_ptr][31:30];
    assign ARADDR  = {ar_mem[rd_ptr][29:0], 2'b00};

    always_ff @(posedge CLK) begin
        if (ar_push)
            ar_mem[wr_ptr] <= {LD_SLICE, LD_ADDR[31:2]};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ar_cnt <= '0;
        end else begin
            if (ar_push) wr_ptr <= ptr_next(wr_ptr);
            if (ar_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({ar_push, ar_pop})
                2'b10:   ar_cnt <= ar_cnt + 1'b1;
                2'b01:   ar_cnt <= ar_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- per-slice context ----------------
    logic             rready_q;
    logic             r_hs, r_match;
    logic [3:0]       slot_set, slot_clr;
    logic [3:0][2:0]  ctx_sel;
    logic [3:0][1:0]  ctx_size, ctx_lane;
    logic [3:0]       ctx_signed;

    always_ff @(posedge CLK) begin
        if (!RST_N) rready_q <= 1'b0;
        else        rready_q <= 1'b1;
    end

    assign RREADY  = rready_q;
    assign r_hs    = RVALID & rready_q;
    assign r_match = r_hs & LD_BUSY[RID];

    genvar s;
    generate
        for (s = 0; s < 4; s++) begin : g_slice
            assign slot_set[s] = ar_push & (LD_SLICE == 2'(s));
            assign slot_clr[s] = r_match & (RID == 2'(s));
            tawas_axi_load_slice u_slice (
                .CLK        (CLK),
                .RST_N      (RST_N),
                .set        (slot_set[s]),
                .clr        (slot_clr[s]),
                .set_sel    (LD_SEL),
                .set_size   (LD_SIZE),
                .set_signed (LD_SIGNED),
                .set_lane   (LD_ADDR[1:0]),
                .busy       (LD_BUSY[s]),
                .ctx_sel    (ctx_sel[s]),
                .ctx_size   (ctx_size[s]),
                .ctx_signed (ctx_signed[s]),
                .ctx_lane   (ctx_lane[s])
            );
        end
    endgenerate

    // ---------------- return data path ----------------
    logic [31:0] r_ext, wb_data;

    assign r_ext = ld_extract(RDATA, ctx_size[RID], ctx_signed[RID], ctx_lane[RID]);

`ifdef TAWAS_AXI_LOAD_ERR_EN
    logic [3:0] err_q;

    // unmatched beats flag the slice too: they indicate a protocol fault upstream
    always_ff @(posedge CLK) begin
        if (!RST_N)
            err_q <= '0;
        else if (r_hs && (!LD_BUSY[RID] || RRESP != 2'b00))
            err_q[RID] <= 1'b1;
    end

    assign LD_ERR  = err_q;
    assign wb_data = (RRESP != 2'b00) ? 32'hDEADBEEF : r_ext;
`else
    logic unused_rresp;
    assign unused_rresp = ^RRESP;
    assign wb_data      = r_ext;
`endif

    // last writeback is held so the register-file port sees stable data between strobes
    logic [1:0]  wb_slice_q;
    logic [2:0]  wb_sel_q;
    logic [31:0] wb_data_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wb_slice_q <= '0;
            wb_sel_q   <= '0;
            wb_data_q  <= '0;
        end else if (r_match) begin
            wb_slice_q <= RID;
            wb_sel_q   <= ctx_sel[RID];
            wb_data_q  <= wb_data;
        end
    end

    generate
        if (WB_REG != 0) begin : g_wb_reg
            logic vld_q;
            always_ff @(posedge CLK) begin
                if (!RST_N) vld_q <= 1'b0;
                else        vld_q <= r_match;
            end
            assign AXI_LOAD_VLD   = vld_q;
            assign AXI_LOAD_SLICE = wb_slice_q;
            assign AXI_LOAD_SEL   = wb_sel_q;
            assign AXI_LOAD       = wb_data_q;
        end else begin : g_wb_comb
            assign AXI_LOAD_VLD   = r_match;
            assign AXI_LOAD_SLICE = r_match ? RID          : wb_slice_q;
            assign AXI_LOAD_SEL   = r_match ? ctx_sel[RID] : wb_sel_q;
            assign AXI_LOAD       = r_match ? wb_data      : wb_data_q;
        end
    endgenerate
endmodule

// File: tb/tb_tawas_axi_load.sv
// Bench for tawas_axi_load: table of single loads plus hand-written ordering/collision/reset sequences.
// AR beats and writebacks are checked against scoreboard queues filled when stimulus is driven.

module tb_tawas_axi_load;
    logic        CLK = 1'b0;
    logic        RST_N, LD_REQ, LD_SIGNED, ARREADY, RVALID;
    logic [1:0]  LD_SLICE, LD_SIZE, RID, RRESP;
    logic [2:0]  LD_SEL;
    logic [31:0] LD_ADDR, RDATA;
    logic        LD_RDY, ARVALID, RREADY, AXI_LOAD_VLD;
    logic [3:0]  LD_BUSY;
    logic [31:0] ARADDR, AXI_LOAD;
    logic [1:0]  ARID, AXI_LOAD_SLICE;
    logic [2:0]  AXI_LOAD_SEL;
`ifdef TAWAS_AXI_LOAD_ERR_EN
    logic [3:0]  LD_ERR;
`endif

    always #5 CLK = ~CLK;

    tawas_axi_load #(.AR_FIFO_DEPTH(4), .WB_REG(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .LD_REQ(LD_REQ), .LD_SLICE(LD_SLICE), .LD_SEL(LD_SEL), .LD_ADDR(LD_ADDR),
        .LD_SIZE(LD_SIZE), .LD_SIGNED(LD_SIGNED), .LD_RDY(LD_RDY), .LD_BUSY(LD_BUSY),
`ifdef TAWAS_AXI_LOAD_ERR_EN
        .LD_ERR(LD_ERR),
`endif
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .AXI_LOAD_VLD(AXI_LOAD_VLD), .AXI_LOAD_SLICE(AXI_LOAD_SLICE),
        .AXI_LOAD_SEL(AXI_LOAD_SEL), .AXI_LOAD(AXI_LOAD)
    );

    typedef struct {
        logic [1:0]  slice;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[8];
    logic [33:0] ar_q[$];   // {ARID, ARADDR}
    logic [36:0] wb_q[$];   // {slice, sel, data}
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // one clock: monitor AR/writeback at the negedge, return 1 unit after the rising edge
    task automatic tick();
        logic [33:0] ea;
        logic [36:0] ew;
        @(negedge CLK);
        if (mon_en && ARVALID && ARREADY) begin
            if (ar_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ar_unexpected got id=%0d addr=%h exp=none", ARID, ARADDR);
            end else begin
                ea = ar_q.pop_front();
                chk("ar_beat", {30'b0, ARID, ARADDR}, {30'b0, ea});
            end
        end
        if (mon_en && AXI_LOAD_VLD) begin
            if (wb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wb_unexpected got slice=%0d sel=%0d data=%h exp=none",
                         AXI_LOAD_SLICE, AXI_LOAD_SEL, AXI_LOAD);
            end else begin
                ew = wb_q.pop_front();
                chk("wb", {27'b0, AXI_LOAD_SLICE, AXI_LOAD_SEL, AXI_LOAD}, {27'b0, ew});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain_ar();
        int n = 0;
        while (ar_q.size() != 0 && n < 20) begin tick(); n++; end
        chk("ar_pending", ar_q.size(), 0);
    endtask

    task automatic drain_wb();
        int n = 0;
        while (wb_q.size() != 0 && n < 10) begin tick(); n++; end
        chk("wb_pending", wb_q.size(), 0);
    endtask

    task automatic do_load(input logic [1:0] slice, input logic [2:0] sel, input logic [31:0] addr,
                           input logic [1:0] size, input logic sgn);
        LD_REQ = 1'b1; LD_SLICE = slice; LD_SEL = sel; LD_ADDR = addr;
        LD_SIZE = size; LD_SIGNED = sgn;
        #1;
        chk("ld_rdy", LD_RDY, 1);
        ar_q.push_back({slice, addr[31:2], 2'b00});
        tick();
        LD_REQ = 1'b0;
        chk("busy_set", LD_BUSY[slice], 1);
    endtask

    task automatic r_beat(input logic [1:0] rid, input logic [31:0] data, input logic [1:0] resp,
                          input logic [2:0] sel, input logic [31:0] exp, input bit expect_wb);
        RVALID = 1'b1; RID = rid; RDATA = data; RRESP = resp;
        if (expect_wb) wb_q.push_back({rid, sel, exp});
        tick();
        RVALID = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; LD_REQ = 1'b0; LD_SLICE = '0; LD_SEL = '0; LD_ADDR = '0; LD_SIZE = '0;
        LD_SIGNED = 1'b0; ARREADY = 1'b1; RVALID = 1'b0; RID = '0; RDATA = '0; RRESP = '0;

        vecs[0] = '{2'd2, 3'd5, 32'h1000_0004, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{2'd0, 3'd1, 32'h2000_0003, 2'd0, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[2] = '{2'd1, 3'd2, 32'h2000_0002, 2'd1, 1'b0, 32'h80FF_0000, 32'h0000_80FF};
        vecs[3] = '{2'd3, 3'd7, 32'h3000_0001, 2'd0, 1'b0, 32'hA1B2_C3D4, 32'h0000_00C3};
        vecs[4] = '{2'd0, 3'd3, 32'h3000_0001, 2'd1, 1'b1, 32'h1234_F00D, 32'hFFFF_F00D};
        vecs[5] = '{2'd1, 3'd4, 32'h4000_000E, 2'd3, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[6] = '{2'd2, 3'd0, 32'h0000_0003, 2'd1, 1'b1, 32'h7FFF_8000, 32'h0000_7FFF};
        vecs[7] = '{2'd3, 3'd6, 32'h0000_0000, 2'd0, 1'b1, 32'h0000_007F, 32'h0000_007F};

        tick(); tick();
        chk("rst_busy", LD_BUSY, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_wb_vld", AXI_LOAD_VLD, 0);
        chk("rst_wb", {AXI_LOAD_SLICE, AXI_LOAD_SEL, AXI_LOAD}, 0);
        RST_N = 1'b1; mon_en = 1'b1;
        tick();
        chk("rready_up", RREADY, 1);

        // table of single loads, one at a time
        foreach (vecs[i]) begin
            do_load(vecs[i].slice, vecs[i].sel, vecs[i].addr, vecs[i].size, vecs[i].sgn);
            chk("ar_latency", ARVALID, 1);
            drain_ar();
            r_beat(vecs[i].slice, vecs[i].rdata, 2'd0, vecs[i].sel, vecs[i].exp, 1'b1);
            chk("busy_clr", LD_BUSY[vecs[i].slice], 0);
            chk("wb_timing", AXI_LOAD_VLD, 1);
            drain_wb();
            chk("wb_pulse_end", AXI_LOAD_VLD, 0);
            chk("wb_hold", AXI_LOAD, vecs[i].exp);
        end

        // four slices queued behind a stalled AR channel, returned out of order
        ARREADY = 1'b0;
        for (int s = 0; s < 4; s++)
            do_load(2'(s), 3'(s + 1), 32'h7000_0000 + 32'(s * 16), 2'd2, 1'b0);
        repeat (3) tick();
        chk("ar_held", ARVALID, 1);
        chk("busy_all", LD_BUSY, 4'hF);
        LD_REQ = 1'b1; LD_SLICE = 2'd1;
        #1;
        chk("rdy_while_busy", LD_RDY, 0);
        LD_REQ = 1'b0;
        ARREADY = 1'b1;
        drain_ar();
        r_beat(2'd3, 32'hA000_0003, 2'd0, 3'd4, 32'hA000_0003, 1'b1);
        r_beat(2'd1, 32'hA000_0001, 2'd0, 3'd2, 32'hA000_0001, 1'b1);
        r_beat(2'd0, 32'hA000_0000, 2'd0, 3'd1, 32'hA000_0000, 1'b1);
        r_beat(2'd2, 32'hA000_0002, 2'd0, 3'd3, 32'hA000_0002, 1'b1);
        drain_wb();
        chk("ooo_busy_clear", LD_BUSY, 0);

        // return and re-request for the same slice in one cycle
        do_load(2'd1, 3'd3, 32'h5000_0008, 2'd2, 1'b0);
        drain_ar();
        RVALID = 1'b1; RID = 2'd1; RDATA = 32'h1111_2222; RRESP = 2'd0;
        LD_REQ = 1'b1; LD_SLICE = 2'd1; LD_SEL = 3'd6; LD_ADDR = 32'h6000_0001;
        LD_SIZE = 2'd0; LD_SIGNED = 1'b0;
        #1;
        chk("collide_rdy", LD_RDY, 0);
        wb_q.push_back({2'd1, 3'd3, 32'h1111_2222});
        tick();
        RVALID = 1'b0;
        #1;
        chk("collide_rdy_next", LD_RDY, 1);
        ar_q.push_back({2'd1, 32'h6000_0000});
        tick();
        LD_REQ = 1'b0;
        drain_ar();
        r_beat(2'd1, 32'h0000_AB00, 2'd0, 3'd6, 32'h0000_00AB, 1'b1);
        drain_wb();

`ifdef TAWAS_AXI_LOAD_ERR_EN
        do_load(2'd3, 3'd2, 32'h8000_0000, 2'd2, 1'b0);
        drain_ar();
        r_beat(2'd3, 32'h1234_5678, 2'd2, 3'd2, 32'hDEAD_BEEF, 1'b1);
        drain_wb();
        chk("ld_err_set", LD_ERR, 4'b1000);
        do_load(2'd3, 3'd1, 32'h8000_0004, 2'd2, 1'b0);
        drain_ar();
        r_beat(2'd3, 32'h0000_0055, 2'd0, 3'd1, 32'h0000_0055, 1'b1);
        drain_wb();
        chk("ld_err_sticky", LD_ERR, 4'b1000);
`endif

        // reset with two loads still queued
        ARREADY = 1'b0;
        do_load(2'd0, 3'd1, 32'h9000_0000, 2'd2, 1'b0);
        do_load(2'd3, 3'd2, 32'h9000_0010, 2'd2, 1'b0);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        ar_q.delete();
        chk("mid_rst_busy", LD_BUSY, 0);
        chk("mid_rst_arvalid", ARVALID, 0);
        chk("mid_rst_rready", RREADY, 0);
`ifdef TAWAS_AXI_LOAD_ERR_EN
        chk("mid_rst_err", LD_ERR, 0);
`endif
        ARREADY = 1'b1;
        tick(); tick();
        chk("post_rst_arvalid", ARVALID, 0);
        r_beat(2'd0, 32'hFFFF_FFFF, 2'd0, 3'd0, 32'h0, 1'b0);
        chk("stale_r_no_wb", AXI_LOAD_VLD, 0);
        tick();
        chk("stale_r_busy", LD_BUSY, 0);
`ifdef TAWAS_AXI_LOAD_ERR_EN
        chk("stale_r_err", LD_ERR, 4'b0001);
`endif
        chk("wb_q_empty", wb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
